// File: rtl/rvh_l1d_refill_ctrl_pkg.sv
// Shared L1D refill definitions: cache geometry defaults and the refill FSM state encoding.
package rvh_l1d_refill_ctrl_pkg;

    localparam int unsigned L1D_ENTRY_IDX = 6;
    localparam int unsigned L1D_WAY_IDX   = 2;
    localparam int unsigned L1D_TAG_W     = 28;
    localparam int unsigned L1D_BEAT_NUM  = 4;
    localparam int unsigned L1D_BEAT_W    = 64;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_VICTIM  = 3'd1,
        S_CHECK   = 3'd2,
        S_WB      = 3'd3,
        S_MEMREQ  = 3'd4,
        S_FILL    = 3'd5,
        S_INSTALL = 3'd6
    } refill_state_e;

endpackage

// File: rtl/rvh_l1d_refill_ctrl_if.sv
// Miss, writeback, line-fetch and fill channels of the L1D refill controller.
interface rvh_l1d_refill_ctrl_if
    import rvh_l1d_refill_ctrl_pkg::*;
#(
    parameter int unsigned ENTRY_IDX = L1D_ENTRY_IDX,
    parameter int unsigned WAY_IDX   = L1D_WAY_IDX,
    parameter int unsigned TAG_W     = L1D_TAG_W,
    parameter int unsigned BEAT_W    = L1D_BEAT_W
) ();

    logic                 miss_valid;
    logic                 miss_ready;
    logic [ENTRY_IDX-1:0] miss_set;
    logic [TAG_W-1:0]     miss_tag;

    logic                 wb_valid;
    logic                 wb_ready;
    logic [ENTRY_IDX-1:0] wb_set;
    logic [WAY_IDX-1:0]   wb_way;
    logic [TAG_W-1:0]     wb_tag;

    logic                 mem_req_valid;
    logic                 mem_req_ready;
    logic [ENTRY_IDX-1:0] mem_req_set;
    logic [TAG_W-1:0]     mem_req_tag;

    logic                 fill_valid;
    logic [BEAT_W-1:0]    fill_data;

    modport master (
        input  miss_valid, miss_set, miss_tag,
        output miss_ready,
        output wb_valid, wb_set, wb_way, wb_tag,
        input  wb_ready,
        output mem_req_valid, mem_req_set, mem_req_tag,
        input  mem_req_ready,
        input  fill_valid, fill_data
    );

    modport slave (
        output miss_valid, miss_set, miss_tag,
        input  miss_ready,
        input  wb_valid, wb_set, wb_way, wb_tag,
        output wb_ready,
        input  mem_req_valid, mem_req_set, mem_req_tag,
        output mem_req_ready,
        output fill_valid, fill_data
    );

endinterface

// File: rtl/rvh_l1d_refill_ctrl.sv
// L1D miss refill controller: victim pick, optional dirty writeback, line fetch,
// beat-by-beat data fill and final tag install. One miss in flight at a time.
module rvh_l1d_refill_ctrl
    import rvh_l1d_refill_ctrl_pkg::*;
#(
    parameter int unsigned ENTRY_IDX = L1D_ENTRY_IDX,
    parameter int unsigned WAY_IDX   = L1D_WAY_IDX,
    parameter int unsigned TAG_W     = L1D_TAG_W,
    parameter int unsigned BEAT_NUM  = L1D_BEAT_NUM,
    parameter int unsigned BEAT_W    = L1D_BEAT_W
) (
    input  logic                        clk,
    input  logic                        rst,
    rvh_l1d_refill_ctrl_if.master       bus,

    output logic                        plru_rd_en,
    output logic [ENTRY_IDX-1:0]        plru_rd_idx,
    input  logic [WAY_IDX-1:0]          plru_rd_way,

    output logic                        meta_rd_en,
    output logic [ENTRY_IDX-1:0]        meta_rd_set,
    output logic [WAY_IDX-1:0]          meta_rd_way,
    input  logic                        meta_rd_valid,
    input  logic                        meta_rd_dirty,
    input  logic [TAG_W-1:0]            meta_rd_tag,

    output logic                        data_wr_en,
    output logic [ENTRY_IDX-1:0]        data_wr_set,
    output logic [WAY_IDX-1:0]          data_wr_way,
    output logic [$clog2(BEAT_NUM)-1:0] data_wr_beat,
    output logic [BEAT_W-1:0]           data_wr_data,

    output logic                        tag_wr_en,
    output logic [ENTRY_IDX-1:0]        tag_wr_set,
    output logic [WAY_IDX-1:0]          tag_wr_way,
    output logic [TAG_W-1:0]            tag_wr_tag,

    output logic                        done,
    output logic [WAY_IDX-1:0]          done_way
);

    localparam int unsigned CNT_W = $clog2(BEAT_NUM);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEAT_NUM - 1);

    refill_state_e        state, state_nxt;
    logic [ENTRY_IDX-1:0] set_q;
    logic [TAG_W-1:0]     tag_q;
    logic [WAY_IDX-1:0]   way_q;
    logic [TAG_W-1:0]     victim_tag_q;
    logic [CNT_W-1:0]     beat_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            set_q        <= '0;
            tag_q        <= '0;
            way_q        <= '0;
            victim_tag_q <= '0;
            beat_q       <= '0;
        end else begin
            case (state)
                S_IDLE: if (bus.miss_valid) begin
                    set_q <= bus.miss_set;
                    tag_q <= bus.miss_tag;
                end
                S_VICTIM: way_q        <= plru_rd_way;
                S_CHECK:  victim_tag_q <= meta_rd_tag;
                S_MEMREQ: if (bus.mem_req_ready) beat_q <= '0;
                // Power-of-two beat count: natural overflow is the modulo wrap.
                S_FILL:   if (bus.fill_valid) beat_q <= beat_q + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (bus.miss_valid) state_nxt = S_VICTIM;
            S_VICTIM:  state_nxt = S_CHECK;
            S_CHECK:   state_nxt = (meta_rd_valid && meta_rd_dirty) ? S_WB : S_MEMREQ;
            S_WB:      if (bus.wb_ready) state_nxt = S_MEMREQ;
            S_MEMREQ:  if (bus.mem_req_ready) state_nxt = S_FILL;
            S_FILL:    if (bus.fill_valid && beat_q == LAST_BEAT) state_nxt = S_INSTALL;
            S_INSTALL: state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.miss_ready    = 1'b0;
        bus.wb_valid      = 1'b0;
        bus.wb_set        = '0;
        bus.wb_way        = '0;
        bus.wb_tag        = '0;
        bus.mem_req_valid = 1'b0;
        bus.mem_req_set   = '0;
        bus.mem_req_tag   = '0;
        plru_rd_en        = 1'b0;
        plru_rd_idx       = '0;
        meta_rd_en        = 1'b0;
        meta_rd_set       = '0;
        meta_rd_way       = '0;
        data_wr_en        = 1'b0;
        data_wr_set       = '0;
        data_wr_way       = '0;
        data_wr_beat      = '0;
        data_wr_data      = '0;
        tag_wr_en         = 1'b0;
        tag_wr_set        = '0;
        tag_wr_way        = '0;
        tag_wr_tag        = '0;
        done              = 1'b0;
        done_way          = '0;
        case (state)
            // Gated by rst so the miss channel closes while reset is held.
            S_IDLE: bus.miss_ready = !rst;
            S_VICTIM: begin
                plru_rd_en  = 1'b1;
                plru_rd_idx = set_q;
                meta_rd_en  = 1'b1;
                meta_rd_set = set_q;
                meta_rd_way = plru_rd_way;
            end
            S_WB: begin
                bus.wb_valid = 1'b1;
                bus.wb_set   = set_q;
                bus.wb_way   = way_q;
                bus.wb_tag   = victim_tag_q;
            end
            S_MEMREQ: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_req_set   = set_q;
                bus.mem_req_tag   = tag_q;
            end
            S_FILL: if (bus.fill_valid) begin
                data_wr_en   = 1'b1;
                data_wr_set  = set_q;
                data_wr_way  = way_q;
                data_wr_beat = beat_q;
                data_wr_data = bus.fill_data;
            end
            S_INSTALL: begin
                tag_wr_en  = 1'b1;
                tag_wr_set = set_q;
                tag_wr_way = way_q;
                tag_wr_tag = tag_q;
                done       = 1'b1;
                done_way   = way_q;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/rvh_l1d_refill_ctrl.md
RVH_L1D_REFILL_CTRL -- requirements
Module: rvh_l1d_refill_ctrl

Interface
REQ-001 SHALL have parameter ENTRY_IDX, default 6, set-index width (must match the PLRU entry_idx).
REQ-002 SHALL have parameter WAY_IDX, default 2, way-index width.
REQ-003 SHALL have parameter TAG_W, default 28, tag width.
REQ-004 SHALL have parameter BEAT_NUM, default 4, fill beats per line (power of two, >=2).
REQ-005 SHALL have parameter BEAT_W, default 64, fill beat width.
REQ-006 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have ports miss_valid/miss_ready, input/output, 1, miss request handshake.
REQ-009 SHALL have ports miss_set, miss_tag, input, ENTRY_IDX/TAG_W, missing line set and tag.
REQ-010 SHALL have ports plru_rd_en, output, 1, and plru_rd_idx, output, ENTRY_IDX: victim query to the PLRU.
REQ-011 SHALL have port plru_rd_way, input, WAY_IDX, combinational victim way returned by the PLRU.
REQ-012 SHALL have ports meta_rd_en, meta_rd_set, meta_rd_way, output, 1/ENTRY_IDX/WAY_IDX: victim metadata read.
REQ-013 SHALL have ports meta_rd_valid, meta_rd_dirty, meta_rd_tag, input, 1/1/TAG_W: metadata, one cycle after meta_rd_en.
REQ-014 SHALL have ports wb_valid/wb_ready, output/input, 1, plus wb_set, wb_way, wb_tag, output: dirty-victim writeback request.
REQ-015 SHALL have ports mem_req_valid/mem_req_ready, output/input, 1, plus mem_req_set, mem_req_tag, output: line fetch.
REQ-016 SHALL have ports fill_valid, input, 1, and fill_data, input, BEAT_W: fill beats, no backpressure.
REQ-017 SHALL have ports data_wr_en, data_wr_set, data_wr_way, data_wr_beat, data_wr_data, output: data-array beat write.
REQ-018 SHALL have ports tag_wr_en, tag_wr_set, tag_wr_way, tag_wr_tag, output: final tag/valid install (dirty cleared).
REQ-019 SHALL have ports done, output, 1, plus done_way, output, WAY_IDX: refill-complete pulse.

Function
REQ-020 SHALL implement FSM IDLE, VICTIM, CHECK, WB, MEMREQ, FILL, INSTALL; one miss at a time.
REQ-021 SHALL assert miss_ready only in IDLE; on miss_valid&miss_ready latch set/tag, go VICTIM.
REQ-022 SHALL, in VICTIM, pulse plru_rd_en for exactly one cycle with plru_rd_idx = latched set, latch plru_rd_way, drive meta_rd_en for that way, go CHECK.
REQ-023 SHALL, in CHECK, go WB if meta_rd_valid&meta_rd_dirty, else MEMREQ; latch meta_rd_tag as wb_tag.
REQ-024 SHALL hold wb_valid and wb_* stable in WB until wb_ready; on handshake go MEMREQ.
REQ-025 SHALL hold mem_req_valid stable in MEMREQ until mem_req_ready; on handshake go FILL with beat counter = 0.
REQ-026 SHALL, in FILL, assert data_wr_en the same cycle as fill_valid (zero latency), data_wr_beat = counter; counter increments by one and wraps modulo BEAT_NUM.
REQ-027 SHALL leave FILL to INSTALL on the beat where counter = BEAT_NUM-1; fill_valid outside FILL is ignored.
REQ-028 SHALL, in INSTALL, pulse tag_wr_en and done for one cycle, then return to IDLE; miss_ready rises the following cycle.
REQ-029 SHALL keep all valid/enable outputs low in states other than those named above.
REQ-030 SHALL never issue plru_rd_en more than once per accepted miss (each pulse advances PLRU state).

Reset
REQ-031 SHALL on rst assertion immediately enter IDLE, clear beat counter and latched fields, drive every output 0 except miss_ready (1 after reset deasserts, 0 while rst high).
REQ-032 SHALL abandon any in-flight refill on reset mid-operation with no tag_wr_en or done emitted.

Structure
REQ-033 SHALL take the FSM state enum and state encoding from the shared rvh_l1d package, alongside the L1D geometry constants.
REQ-034 SHALL be a single module with no sub-modules; the PLRU is instantiated by the parent and connected via plru_* ports.

Verification
REQ-035 Clean victim: miss set=5 tag=0x123, plru_rd_way=2, meta valid=1 dirty=0 -> no wb_valid; mem_req set=5; 4 beats written way 2 beats 0..3; tag_wr way 2 tag 0x123; done_way=2.
REQ-036 Dirty victim: meta dirty=1 tag=0x0AA, wb_ready held low 3 cycles -> wb_valid held 3+1 cycles with wb_tag=0x0AA stable, then MEMREQ.
REQ-037 Gapped fill: fill_valid on cycles 0,2,5,6 -> data_wr_beat 0,1,2,3 on exactly those cycles; done one cycle after last beat.
REQ-038 Back-to-back: second miss_valid held during first refill -> accepted only in IDLE after done; exactly two plru_rd_en pulses total.
REQ-039 Reset in FILL after 2 beats -> outputs 0 asynchronously, no done/tag_wr; next miss starts at beat 0.
REQ-040 Spurious fill_valid in IDLE/WB -> no data_wr_en.
